// File: rtl/jzjpcc_rf_write_arbiter_if.sv
// Bus bundle for jzjpcc_rf_write_arbiter.
// It groups the writeback request, the long-latency result handshake,
// the register-file write port and the hazard query.
// The arbiter uses the slave modport. The driving side uses the master modport.
interface jzjpcc_rf_write_arbiter_if;
    logic [4:0]  rdAddr_wb;
    logic [31:0] rd_wb;
    logic        rdWriteEnable_wb;
    logic        stall_wb;

    logic        lr_valid;
    logic        lr_ready;
    logic [4:0]  lr_rdAddr;
    logic [31:0] lr_data;

    logic [4:0]  rdAddr_rf;
    logic [31:0] rd_rf;
    logic        rdWriteEnable_rf;

    logic [4:0]  pendQueryAddr;
    logic        pendHit;

    modport master (
        output rdAddr_wb, rd_wb, rdWriteEnable_wb,
        output lr_valid, lr_rdAddr, lr_data,
        output pendQueryAddr,
        input  stall_wb, lr_ready,
        input  rdAddr_rf, rd_rf, rdWriteEnable_rf,
        input  pendHit
    );

    modport slave (
        input  rdAddr_wb, rd_wb, rdWriteEnable_wb,
        input  lr_valid, lr_rdAddr, lr_data,
        input  pendQueryAddr,
        output stall_wb, lr_ready,
        output rdAddr_rf, rd_rf, rdWriteEnable_rf,
        output pendHit
    );
endinterface

// File: rtl/jzjpcc_rf_write_arbiter.sv
// jzjpcc_rf_write_arbiter: shares the single register-file write port
// between the in-order writeback stage and a long-latency result source.
//
// Long-latency results are parked in a small FIFO. They drain into cycles
// where writeback does not write. An aging counter (waitCount) bounds how
// long a non-empty FIFO can lose to writeback. Once it reaches MAX_WAIT,
// the head is forced out and writeback is stalled for one cycle.
//
// Optional feature: define JZJPCC_WBARB_PENDQUERY_EN to build the per-entry
// pending-write comparators that drive pendHit. Without it, pendHit is 0.
//
// FIFO_DEPTH must be a power of two >= 2, so the pointers wrap naturally.
// MAX_WAIT must be in 1..15.
module jzjpcc_rf_write_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    jzjpcc_rf_write_arbiter_if.slave   bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    fifoAddr [FIFO_DEPTH];
    logic [31:0]   fifoData [FIFO_DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] count;
    logic [3:0]    waitCount;

    logic          pipeReq;
    logic          fifoHave;
    logic          fifoFull;
    logic          lrReady;
    logic          storeEn;
    logic          popEn;
    logic          pipeGrant;
    logic          stallOut;
    logic          waitMax;
    logic          pendHitInt;

    // Classify this cycle's requests from the registered FIFO state.
    always_comb begin
        pipeReq   = bus.rdWriteEnable_wb && (bus.rdAddr_wb != 5'd0);
        fifoHave  = (count != '0);
        fifoFull  = (count == CW'(FIFO_DEPTH));
        waitMax   = (waitCount == 4'(MAX_WAIT));
        // While in reset the port advertises no space.
        lrReady   = reset_n && !fifoFull;
        // Results to x0 are taken off the bus but never stored.
        storeEn   = bus.lr_valid && lrReady && (bus.lr_rdAddr != 5'd0);
        popEn     = reset_n && fifoHave && (!pipeReq || waitMax);
        pipeGrant = reset_n && pipeReq && !popEn;
        stallOut  = popEn && pipeReq;
    end

    // Drive the register-file write port from whichever source won.
    always_comb begin
        bus.rdWriteEnable_rf = 1'b0;
        bus.rdAddr_rf        = 5'd0;
        bus.rd_rf            = 32'd0;
        if (popEn) begin
            bus.rdWriteEnable_rf = 1'b1;
            bus.rdAddr_rf        = fifoAddr[headPtr];
            bus.rd_rf            = fifoData[headPtr];
        end else if (pipeGrant) begin
            bus.rdWriteEnable_rf = 1'b1;
            bus.rdAddr_rf        = bus.rdAddr_wb;
            bus.rd_rf            = bus.rd_wb;
        end
    end

    assign bus.stall_wb = stallOut;
    assign bus.lr_ready = lrReady;
    assign bus.pendHit  = pendHitInt;

    // FIFO pointers and occupancy. Reset drops everything buffered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (storeEn) begin
                tailPtr <= tailPtr + PW'(1);
            end
            if (popEn) begin
                headPtr <= headPtr + PW'(1);
            end
            case ({storeEn, popEn})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Aging counter: it counts the cycles a non-empty FIFO loses to writeback.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            waitCount <= 4'd0;
        end else if (popEn || !fifoHave) begin
            waitCount <= 4'd0;
        end else if (pipeGrant) begin
            waitCount <= waitCount + 4'd1;
        end
    end

    // Entry storage. Validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clock) begin
        if (storeEn) begin
            fifoAddr[tailPtr] <= bus.lr_rdAddr;
            fifoData[tailPtr] <= bus.lr_data;
        end
    end

`ifdef JZJPCC_WBARB_PENDQUERY_EN
    logic [PW-1:0] entryOffset;

    // Pending-write lookup over the live entries. The head is still counted
    // in the cycle it pops.
    always_comb begin
        pendHitInt  = 1'b0;
        entryOffset = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            entryOffset = PW'(i) - headPtr;
            if (({1'b0, entryOffset} < count) && (fifoAddr[i] == bus.pendQueryAddr)) begin
                pendHitInt = 1'b1;
            end
        end
        if (!reset_n || (bus.pendQueryAddr == 5'd0)) begin
            pendHitInt = 1'b0;
        end
    end
`else
    logic unusedPendQuery;

    // No comparators in this build. The query address is ignored.
    always_comb begin
        pendHitInt      = 1'b0;
        unusedPendQuery = ^bus.pendQueryAddr;
    end
`endif

endmodule

// File: tb/tb_jzjpcc_rf_write_arbiter.sv
// Bench for jzjpcc_rf_write_arbiter.
// The driver sets inputs and runs a queue-based reference model.
// It pushes the expected register-file writes into expQ.
// The monitor compares every cycle on the falling edge.
module tb_jzjpcc_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int MAXW  = 4;
`ifdef JZJPCC_WBARB_PENDQUERY_EN
    localparam bit PQ = 1'b1;
`else
    localparam bit PQ = 1'b0;
`endif

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    jzjpcc_rf_write_arbiter_if bus();

    jzjpcc_rf_write_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    ent_t expQ[$];
    int   mw = 0;
    bit   expStall = 0;
    bit   expReady = 0;
    bit   expHit = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: it evaluates one cycle from the current inputs, then advances.
    task automatic model();
        bit   p;
        bit   h;
        ent_t e;
        if (!reset_n) begin
            mq.delete();
            mw = 0;
            expStall = 0;
            expReady = 0;
            expHit = 0;
            return;
        end
        p = bus.rdWriteEnable_wb && (bus.rdAddr_wb != 0);
        h = (mq.size() > 0);
        expReady = (mq.size() < DEPTH);
        expHit = 0;
        if (PQ && bus.pendQueryAddr != 0)
            foreach (mq[i]) if (mq[i].a == bus.pendQueryAddr) expHit = 1;
        expStall = 0;
        if (!h) begin
            mw = 0;
            if (p) begin e.a = bus.rdAddr_wb; e.d = bus.rd_wb; expQ.push_back(e); end
        end else if (!p || mw == MAXW) begin
            expStall = p;
            expQ.push_back(mq.pop_front());
            mw = 0;
        end else begin
            e.a = bus.rdAddr_wb; e.d = bus.rd_wb; expQ.push_back(e);
            mw++;
        end
        if (bus.lr_valid && expReady && bus.lr_rdAddr != 0) begin
            e.a = bus.lr_rdAddr; e.d = bus.lr_data; mq.push_back(e);
        end
    endtask

    task automatic step(bit rst, bit we, logic [4:0] a, logic [31:0] d,
                        bit lv, logic [4:0] la, logic [31:0] ld, logic [4:0] q);
        @(posedge clock);
        #1;
        reset_n = !rst;
        bus.rdWriteEnable_wb = we;
        bus.rdAddr_wb = a;
        bus.rd_wb = d;
        bus.lr_valid = lv;
        bus.lr_rdAddr = la;
        bus.lr_data = ld;
        bus.pendQueryAddr = q;
        model();
        @(negedge clock);
    endtask

    task automatic idle(logic [4:0] q = 5'd0);
        step(0, 0, 0, 0, 0, 0, 0, q);
    endtask

    // Monitor: it pops expected writes and checks the per-cycle controls.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                chk("rst_we", bus.rdWriteEnable_rf, 0);
                chk("rst_stall", bus.stall_wb, 0);
                chk("rst_ready", bus.lr_ready, 0);
                chk("rst_hit", bus.pendHit, 0);
                chk("rst_addr", bus.rdAddr_rf, 0);
                chk("rst_data", bus.rd_rf, 0);
            end else begin
                chk("stall", bus.stall_wb, expStall);
                chk("lr_ready", bus.lr_ready, expReady);
                chk("pendHit", bus.pendHit, expHit);
                if (bus.rdWriteEnable_rf) begin
                    if (expQ.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        chk("wr_addr", bus.rdAddr_rf, e.a);
                        chk("wr_data", bus.rd_rf, e.d);
                    end
                end else begin
                    chk("idle_addr", bus.rdAddr_rf, 0);
                    chk("idle_data", bus.rd_rf, 0);
                    if (expQ.size() != 0) begin
                        void'(expQ.pop_front());
                        chk("missing_write", 0, 1);
                    end
                end
            end
        end
    end

    // Watchdog: it ends the run if the stimulus ever stops advancing.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        bit          we, lv, hold;
        logic [4:0]  a, la, q;
        logic [31:0] d, ld;

        bus.rdWriteEnable_wb = 0; bus.rdAddr_wb = 0; bus.rd_wb = 0;
        bus.lr_valid = 0; bus.lr_rdAddr = 0; bus.lr_data = 0; bus.pendQueryAddr = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_ready", bus.lr_ready, 0);
        step(1, 1, 5, 32'h1, 1, 4, 32'h2, 4);
        chk("reset_we_blocked", bus.rdWriteEnable_rf, 0);
        idle();
        chk("ready_after_reset", bus.lr_ready, 1);

        // A pipeline write to an empty FIFO passes through in the same cycle.
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("pass_we", bus.rdWriteEnable_rf, 1);
        chk("pass_addr", bus.rdAddr_rf, 5);
        chk("pass_data", bus.rd_rf, 32'hDEADBEEF);
        chk("pass_stall", bus.stall_wb, 0);

        // x0 pipeline write is dropped.
        step(0, 1, 0, 32'h77, 0, 0, 0, 0);
        chk("x0_we", bus.rdWriteEnable_rf, 0);

        // A single enqueue drains in the next idle cycle.
        step(0, 0, 0, 0, 1, 7, 32'h11, 0);
        chk("enq_no_write", bus.rdWriteEnable_rf, 0);
        idle();
        chk("drain_addr", bus.rdAddr_rf, 7);
        chk("drain_data", bus.rd_rf, 32'h11);
        chk("drain_ready", bus.lr_ready, 1);
        idle();
        chk("drained_empty", bus.rdWriteEnable_rf, 0);

        // Aging: the pipeline wins MAX_WAIT cycles, then a forced drain stalls it once.
        step(0, 1, 4, 32'h44, 1, 3, 32'h33, 0);
        chk("age_enq_pass", bus.rdAddr_rf, 4);
        for (int i = 0; i < MAXW; i++) begin
            step(0, 1, 4, 32'h44, 0, 0, 0, 0);
            chk("age_pipe_addr", bus.rdAddr_rf, 4);
            chk("age_pipe_stall", bus.stall_wb, 0);
        end
        step(0, 1, 4, 32'h44, 0, 0, 0, 0);
        chk("age_force_addr", bus.rdAddr_rf, 3);
        chk("age_force_data", bus.rd_rf, 32'h33);
        chk("age_force_stall", bus.stall_wb, 1);
        step(0, 1, 4, 32'h44, 0, 0, 0, 0);
        chk("age_resume_addr", bus.rdAddr_rf, 4);
        chk("age_resume_stall", bus.stall_wb, 0);
        idle();

        // Full FIFO back-pressure and the pending-write query.
        step(0, 1, 4, 32'h44, 1, 1, 32'h1, 0);
        step(0, 1, 4, 32'h44, 1, 2, 32'h2, 2);
        step(0, 1, 4, 32'h44, 1, 6, 32'h6, 2);
        chk("full_ready", bus.lr_ready, 0);
        chk("full_hit", bus.pendHit, PQ);
        idle(2);
        chk("full_pop1", bus.rdAddr_rf, 1);
        chk("pop1_hit", bus.pendHit, PQ);
        idle(2);
        chk("full_pop2", bus.rdAddr_rf, 2);
        chk("pop2_hit", bus.pendHit, PQ);
        idle(2);
        chk("after_pop_hit", bus.pendHit, 0);
        chk("x6_rejected", bus.rdWriteEnable_rf, 0);

        // A reset in mid-stream discards the buffered x9.
        step(0, 0, 0, 0, 1, 9, 32'h9, 0);
        step(1, 1, 8, 32'h8, 0, 0, 0, 9);
        chk("midrst_we", bus.rdWriteEnable_rf, 0);
        chk("midrst_ready", bus.lr_ready, 0);
        idle(9);
        chk("post_rst_we", bus.rdWriteEnable_rf, 0);
        chk("post_rst_ready", bus.lr_ready, 1);
        chk("post_rst_hit", bus.pendHit, 0);
        idle();
        chk("x9_gone", bus.rdWriteEnable_rf, 0);
        step(0, 0, 0, 0, 1, 0, 32'h55, 0);
        idle();
        chk("x0_enq_no_write", bus.rdWriteEnable_rf, 0);

        // Random traffic. A stalled writeback request is held for the next cycle.
        hold = 0;
        we = 0; a = 0; d = 0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                we = ($urandom_range(0, 99) < 65);
                a  = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 9) == 0) a = 0;
                d  = $urandom;
            end
            lv = ($urandom_range(0, 99) < 45);
            la = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) la = 0;
            ld = $urandom;
            q  = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].a : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 199) == 0), we, a, d, lv, la, ld, q);
            hold = expStall;
        end
        for (int n = 0; n < 8; n++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
